// File: rtl/tpram_rd_seq.sv
// rtl/tpram_rd_seq.sv - TPRAM read sequencer feeding a 2-entry element stream
//
// Purpose:
//   Walks the two-port RAM read port from a starting byte address for a given
//   number of dword/word/byte elements. The data for each element is shaped to
//   32 bits and delivered on a ready/valid stream through a 2-entry FIFO.
//   The RAM returns read data one cycle after the address is presented.
//
// Ports:
//   EFPGA_TPRAM_R_CLK   in   clock, all state on rising edge
//   r_addr_ff_rstn      in   asynchronous active-low reset
//   start               in   one-cycle request, cfg_* sampled with it
//   cfg_addr[11:0]      in   starting byte address
//   cfg_len[12:0]       in   element count 0..4096
//   cfg_mode[1:0]       in   00 dword, 01 word, 10 byte, 11 as dword
//   abort               in   cancel the transfer in progress
//   EFPGA_TPRAM_R_ADDR  out  RAM read byte address
//   EFPGA_TPRAM_R_MODE  out  RAM read mode (never 11)
//   TPRAM_EFPGA_R_DATA  in   RAM read data, one cycle after the address
//   m_valid/m_ready     out/in  element stream handshake
//   m_data[31:0]        out  element, extended per SIGN_EXT
//   m_last              out  high with the final element
//   busy                out  transfer in progress (state != IDLE)
//   done                out  one-cycle completion pulse

module tpram_rd_seq #(
  parameter int SIGN_EXT = 0
) (
  input  logic        EFPGA_TPRAM_R_CLK,
  input  logic        r_addr_ff_rstn,
  input  logic        start,
  input  logic [11:0] cfg_addr,
  input  logic [12:0] cfg_len,
  input  logic [1:0]  cfg_mode,
  input  logic        abort,
  output logic [11:0] EFPGA_TPRAM_R_ADDR,
  output logic [1:0]  EFPGA_TPRAM_R_MODE,
  input  logic [31:0] TPRAM_EFPGA_R_DATA,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  mode_q, mode_d;
  logic [12:0] len_q, len_d;
  logic [12:0] iss_cnt_q, iss_cnt_d;
  logic        inflight_q, inflight_d;
  logic        infl_last_q, infl_last_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;
  logic        last0_q, last0_d;
  logic        last1_q, last1_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic        final_issue;
  logic        start_ok;
  logic        flush;
  logic [2:0]  occ;
  logic [11:0] step;
  logic [31:0] shaped;

  function automatic logic [31:0] shape(input logic [1:0] mode, input logic [31:0] raw);
    logic [31:0] r;
    case (mode)
      2'b01:   r = (SIGN_EXT != 0) ? {{16{raw[15]}}, raw[15:0]} : {16'h0000, raw[15:0]};
      2'b10:   r = (SIGN_EXT != 0) ? {{24{raw[7]}}, raw[7:0]} : {24'h000000, raw[7:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // Handshake and issue qualification.
  always_comb begin
    pop      = (cnt_q != 2'd0) && m_ready;
    push     = inflight_q && !abort;
    start_ok = (state_q == S_IDLE) && start && !abort;
    flush    = abort && (state_q != S_IDLE);
    // FIFO entries plus the read still in flight, after this cycle's pop.
    // Keeping this below 2 before issuing guarantees the returning data
    // always has a free slot.
    occ         = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue       = (state_q == S_RUN) && !abort && (occ < 3'd2);
    final_issue = issue && (iss_cnt_q == len_q - 13'd1);
    case (mode_q)
      2'b01:   step = 12'd2;
      2'b10:   step = 12'd1;
      default: step = 12'd4;
    endcase
    shaped = shape(mode_q, TPRAM_EFPGA_R_DATA);
  end

  // State register.
  always_ff @(posedge EFPGA_TPRAM_R_CLK or negedge r_addr_ff_rstn) begin
    if (!r_addr_ff_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = (cfg_len == 13'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (final_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ((cnt_q == 2'd0) && !inflight_q) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    busy               = (state_q != S_IDLE);
    // An abort landing on the DONE cycle cancels the completion pulse.
    done               = (state_q == S_DONE) && !abort;
    m_valid            = (cnt_q != 2'd0);
    m_data             = 32'h0;
    m_last             = 1'b0;
    if (cnt_q != 2'd0) begin
      m_data = rd_ptr_q ? data1_q : data0_q;
      m_last = rd_ptr_q ? last1_q : last0_q;
    end
    EFPGA_TPRAM_R_ADDR = addr_q;
    EFPGA_TPRAM_R_MODE = mode_q;
  end

  // Datapath next values: address walker, read tracking and FIFO.
  always_comb begin
    addr_d      = addr_q;
    mode_d      = mode_q;
    len_d       = len_q;
    iss_cnt_d   = iss_cnt_q;
    inflight_d  = issue;
    infl_last_d = issue ? final_issue : 1'b0;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;

    if (start_ok) begin
      addr_d    = cfg_addr;
      // Mode 11 is folded to dword here so the RAM never sees it.
      mode_d    = (cfg_mode == 2'b11) ? 2'b00 : cfg_mode;
      len_d     = cfg_len;
      iss_cnt_d = 13'd0;
    end

    if (issue) begin
      addr_d    = addr_q + step;
      iss_cnt_d = iss_cnt_q + 13'd1;
    end

    if (push) begin
      if (wr_ptr_q) begin
        data1_d = shaped;
        last1_d = infl_last_q;
      end else begin
        data0_d = shaped;
        last0_d = infl_last_q;
      end
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    if (flush) begin
      cnt_d       = 2'd0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      inflight_d  = 1'b0;
      infl_last_d = 1'b0;
    end
  end

  always_ff @(posedge EFPGA_TPRAM_R_CLK or negedge r_addr_ff_rstn) begin
    if (!r_addr_ff_rstn) begin
      addr_q      <= 12'h000;
      mode_q      <= 2'b00;
      len_q       <= 13'd0;
      iss_cnt_q   <= 13'd0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      data0_q     <= 32'h0;
      data1_q     <= 32'h0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      iss_cnt_q   <= iss_cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
    end
  end

endmodule

// File: tb/tb_tpram_rd_seq.sv
// tb/tb_tpram_rd_seq.sv - self-checking bench for tpram_rd_seq (both SIGN_EXT settings)
//
// Purpose:
//   Drives directed transfers into a zero-extending and a sign-extending
//   instance side by side, with a RAM model returning an address-derived word
//   one cycle after each address. An element queue built from the transfer
//   parameters is checked against the stream every cycle.

module tb_tpram_rd_seq;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        last;
  } elem_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start, abort, m_ready;
  logic [11:0] cfg_addr;
  logic [12:0] cfg_len;
  logic [1:0]  cfg_mode;

  logic [11:0] ra0, ra1, ram_a0, ram_a1;
  logic [1:0]  rm0, rm1;
  logic [31:0] rd0, rd1, d0, d1;
  logic        v0, v1, l0, l1, b0, b1, dn0, dn1;

  int          total = 0;
  int          bad = 0;
  int          hs_cnt = 0;
  logic        prev_hold = 1'b0;
  elem_t       exp_q[$];

  // Test-local scratch.
  logic [11:0] s_addr [1:9];
  logic [9:1]  s_valid, s_last, s_done, s_busy;
  logic [11:0] t1_addr_e [1:5];
  logic [9:1]  t1_valid_e, t1_last_e, t1_done_e, t1_busy_e;
  logic [11:0] fz;
  int          n, h0, iss;

  tpram_rd_seq #(.SIGN_EXT(0)) u_dut0 (
    .EFPGA_TPRAM_R_CLK (clk),
    .r_addr_ff_rstn    (rstn),
    .start             (start),
    .cfg_addr          (cfg_addr),
    .cfg_len           (cfg_len),
    .cfg_mode          (cfg_mode),
    .abort             (abort),
    .EFPGA_TPRAM_R_ADDR(ra0),
    .EFPGA_TPRAM_R_MODE(rm0),
    .TPRAM_EFPGA_R_DATA(rd0),
    .m_valid           (v0),
    .m_ready           (m_ready),
    .m_data            (d0),
    .m_last            (l0),
    .busy              (b0),
    .done              (dn0)
  );

  tpram_rd_seq #(.SIGN_EXT(1)) u_dut1 (
    .EFPGA_TPRAM_R_CLK (clk),
    .r_addr_ff_rstn    (rstn),
    .start             (start),
    .cfg_addr          (cfg_addr),
    .cfg_len           (cfg_len),
    .cfg_mode          (cfg_mode),
    .abort             (abort),
    .EFPGA_TPRAM_R_ADDR(ra1),
    .EFPGA_TPRAM_R_MODE(rm1),
    .TPRAM_EFPGA_R_DATA(rd1),
    .m_valid           (v1),
    .m_ready           (m_ready),
    .m_data            (d1),
    .m_last            (l1),
    .busy              (b1),
    .done              (dn1)
  );

  // Byte 0 = a[7:0]^C3, bits 15:8 = a[7:0], so address 0x030 gives byte 0xF3.
  function automatic logic [31:0] ram_word(input logic [11:0] a);
    return {a[7:0] ^ 8'h5A, 4'h0, a, a[7:0] ^ 8'hC3};
  endfunction

  function automatic logic [31:0] exp_elem(input logic [11:0] a, input logic [1:0] mode, input logic sx);
    logic [31:0] w;
    logic [31:0] r;
    w = ram_word(a);
    case (mode)
      2'b01:   r = sx ? {{16{w[15]}}, w[15:0]} : {16'h0000, w[15:0]};
      2'b10:   r = sx ? {{24{w[7]}}, w[7:0]} : {24'h000000, w[7:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // RAM model: registers the address, data appears the following cycle.
  always @(posedge clk) begin
    ram_a0 <= ra0;
    ram_a1 <= ra1;
  end
  assign rd0 = ram_word(ram_a0);
  assign rd1 = ram_word(ram_a1);

  always @(posedge clk) begin
    if (rstn && v0 && m_ready) hs_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fill_model(input logic [11:0] addr, input logic [12:0] len, input logic [1:0] mode);
    logic [11:0] a;
    elem_t       e;
    int          step;
    a = addr;
    step = (mode == 2'b01) ? 2 : ((mode == 2'b10) ? 1 : 4);
    for (int i = 0; i < int'(len); i++) begin
      e.d0   = exp_elem(a, mode, 1'b0);
      e.d1   = exp_elem(a, mode, 1'b1);
      e.last = (i == int'(len) - 1);
      exp_q.push_back(e);
      a = a + step[11:0];
    end
  endtask

  // Call at posedge+1 while idle; returns at posedge+1 of the first busy cycle.
  task automatic start_xfer(input logic [11:0] addr, input logic [12:0] len, input logic [1:0] mode);
    start    = 1'b1;
    cfg_addr = addr;
    cfg_len  = len;
    cfg_mode = mode;
    fill_model(addr, len, mode);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int busy_n);
    int k;
    int dc;
    k = 0;
    dc = 0;
    while (k < budget) begin
      @(negedge clk);
      if (dn0) dc++;
      if (!b0) break;
      k++;
    end
    busy_n = k;
    chk({name, "_timeout"}, 32'(k < budget), 1);
    chk({name, "_done_pulses"}, dc, 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Stream checker against the element queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (prev_hold) chk("hold_valid", v0, 1);
      chk("valid_pair", v1, v0);
      if (v0) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("data_zext", d0, exp_q[0].d0);
          chk("data_sext", d1, exp_q[0].d1);
          chk("last", l0, exp_q[0].last);
          if (m_ready) exp_q.delete(0);
        end
      end
      prev_hold = v0 && !m_ready && !abort;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    cfg_addr = 12'h000; cfg_len = 13'd0; cfg_mode = 2'b00;
    t1_addr_e  = '{12'h010, 12'h014, 12'h018, 12'h01C, 12'h020};
    t1_valid_e = 9'b000111100;
    t1_last_e  = 9'b000100000;
    t1_done_e  = 9'b010000000;
    t1_busy_e  = 9'b011111111;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", ra0, 12'h000);
    chk("rst_mode", rm0, 2'b00);
    chk("rst_valid", v0, 0);
    chk("rst_last", l0, 0);
    chk("rst_data", d1, 32'h0);
    chk("rst_busy", b0, 0);
    chk("rst_done", dn0, 0);

    // Dword 0x010 len 4, started on the reset-release cycle.
    rstn = 1'b1;
    start_xfer(12'h010, 13'd4, 2'b00);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      s_addr[c]  = ra0;
      s_valid[c] = v0;
      s_last[c]  = l0;
      s_done[c]  = dn0;
      s_busy[c]  = b0;
    end
    for (int c = 1; c <= 5; c++) chk($sformatf("t1_addr_c%0d", c), s_addr[c], t1_addr_e[c]);
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("t1_valid_c%0d", c), s_valid[c], t1_valid_e[c]);
      chk($sformatf("t1_last_c%0d", c), s_last[c], t1_last_e[c]);
      chk($sformatf("t1_done_c%0d", c), s_done[c], t1_done_e[c]);
      chk($sformatf("t1_busy_c%0d", c), s_busy[c], t1_busy_e[c]);
    end
    chk("t1_drained", exp_q.size(), 0);

    // Byte mode, RAM byte 0xF3.
    @(posedge clk); #1;
    start_xfer(12'h030, 13'd3, 2'b10);
    @(negedge clk);
    chk("t2_rmode", rm0, 2'b10);
    chk("t2_addr0", ra0, 12'h030);
    n = 0;
    while (!v0 && n < 8) begin @(negedge clk); n++; end
    chk("t2_first_valid", v0, 1);
    chk("t2_zext_lit", d0, 32'h000000F3);
    chk("t2_sext_lit", d1, 32'hFFFFFFF3);
    wait_idle("t2", 20, n);

    // Word mode wrapping at the top of the address space.
    @(posedge clk); #1;
    start_xfer(12'hFFE, 13'd2, 2'b01);
    @(negedge clk);
    chk("t3_addr0", ra0, 12'hFFE);
    chk("t3_rmode", rm0, 2'b01);
    @(negedge clk);
    chk("t3_addr1", ra0, 12'h000);
    @(negedge clk);
    chk("t3_first_valid", v0, 1);
    chk("t3_zext_lit", d0, 32'h0000FE3D);
    chk("t3_sext_lit", d1, 32'hFFFFFE3D);
    wait_idle("t3", 20, n);

    // Backpressure for 5 cycles, plus a start while busy that must be ignored.
    @(posedge clk); #1;
    h0 = hs_cnt;
    start_xfer(12'h100, 13'd8, 2'b00);
    for (int c = 1; c <= 9; c++) begin
      m_ready = !(c >= 4 && c <= 8);
      if (c == 2) begin
        start = 1'b1; cfg_addr = 12'h7F0; cfg_len = 13'd1; cfg_mode = 2'b10;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      iss = int'(ra0 - 12'h100) >> 2;
      chk($sformatf("t4_outstanding_c%0d", c), 32'((iss - (hs_cnt - h0)) <= 2), 1);
      if (c == 5) fz = ra0;
      if (c == 8) begin
        chk("t4_addr_frozen", ra0, fz);
        chk("t4_addr_frozen_lit", ra0, 12'h10C);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_idle("t4", 40, n);

    // Zero-length transfer.
    @(posedge clk); #1;
    start_xfer(12'h055, 13'd0, 2'b00);
    wait_idle("t5", 10, n);
    chk("t5_busy_cycles", n, 1);

    // Abort on the DONE cycle suppresses done.
    @(posedge clk); #1;
    start_xfer(12'h066, 13'd0, 2'b00);
    abort = 1'b1;
    @(negedge clk);
    chk("t5b_busy", b0, 1);
    chk("t5b_done_suppressed", dn0, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t5b_idle", b0, 0);
    chk("t5b_no_done", dn0, 0);

    // Abort two beats into a len-8 transfer.
    @(posedge clk); #1;
    start_xfer(12'h200, 13'd8, 2'b00);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("t6_busy_in_abort", b0, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_valid_after", v0, 0);
      chk("t6_busy_after", b0, 0);
      chk("t6_done_after", dn0, 0);
    end

    // Start and abort together in IDLE: nothing starts.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; cfg_addr = 12'h300; cfg_len = 13'd2; cfg_mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6b_busy", b0, 0);
      chk("t6b_valid", v0, 0);
    end

    // Clean run after abort, mode 11 behaves as dword.
    @(posedge clk); #1;
    start_xfer(12'h3F8, 13'd4, 2'b11);
    @(negedge clk);
    chk("t6c_rmode", rm0, 2'b00);
    chk("t6c_addr0", ra0, 12'h3F8);
    wait_idle("t6c", 30, n);

    // Reset two beats into a len-8 transfer.
    @(posedge clk); #1;
    start_xfer(12'h400, 13'd8, 2'b01);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("t7_rst_valid", v0, 0);
    chk("t7_rst_busy", b0, 0);
    chk("t7_rst_done", dn0, 0);
    chk("t7_rst_addr", ra0, 12'h000);
    chk("t7_rst_data", d0, 32'h0);
    chk("t7_rst_last", l0, 0);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("t7_in_rst_done", dn0, 0);
      @(posedge clk);
    end
    #1;
    rstn = 1'b1;
    start_xfer(12'h7FC, 13'd3, 2'b00);
    @(negedge clk);
    chk("t7_first_start", b0, 1);
    wait_idle("t7", 30, n);

    // Full 4096-byte transfer wraps the address back to the start.
    @(posedge clk); #1;
    start_xfer(12'h123, 13'd4096, 2'b10);
    wait_idle("t8", 4200, n);
    chk("t8_addr_wrap", ra0, 12'h123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
